serial_sample_loader: RTL
=========================

SERIAL_SAMPLE_LOADER -- requirements
Module: serial_sample_loader

Interface
REQ-001 Parameter NUM_SAMPLES, default 15: highest sample index; samples 0..NUM_SAMPLES loaded (NUM_SAMPLES+1 total).
REQ-002 Parameter HEADER_BYTE, default 8'hA5: frame start marker.
REQ-003 Single clock; reset synchronous, active-high.
REQ-004 iClock  input  1  rising-edge clock.
REQ-005 iReset  input  1  synchronous active-high reset.
REQ-006 iRxValid  input  1  one-cycle strobe, iRxData valid.
REQ-007 iRxData  input  8  received serial byte.
REQ-008 iNextSample  input  1  downstream sample store idle, may accept a request.
REQ-009 oPreparingNextSample  output  1  one-cycle request to downstream store.
REQ-010 oWriteSample  output  1  one-cycle write strobe to downstream store.
REQ-011 oCurrentSerialInput  output  [3:0][7:0]  assembled input word.
REQ-012 oCurrentSerialExpectedOutput  output  [3:0][7:0]  assembled expected output.
REQ-013 oCurrentSerialValidOutput  output  [3:0][7:0]  assembled valid-bit mask.
REQ-014 oSampleIndex  output  32  index of sample being written.
REQ-015 oLoadDone  output  1  level, all samples written.
REQ-016 oFrameError  output  1  one-cycle pulse, frame dropped.
REQ-017 oOverrun  output  1  one-cycle pulse, byte dropped while busy.

Function
REQ-018 States SHALL be HUNT, PAYLOAD, CHECK, REQUEST, WRITE, DONE.
REQ-019 HUNT: iRxValid with iRxData==HEADER_BYTE -> PAYLOAD, byte counter cleared; other bytes ignored, no pulses.
REQ-020 PAYLOAD: accept exactly 12 bytes; byte n (0..3) -> Input[n], 4..7 -> ExpectedOutput[n-4], 8..11 -> ValidOutput[n-8]; HEADER_BYTE inside payload is plain data.
REQ-021 After byte 11: -> CHECK if SAMPLE_CHECKSUM_EN defined, else -> REQUEST.
REQ-022 REQUEST: when iNextSample==1, assert oPreparingNextSample for exactly one cycle, -> WRITE; otherwise hold indefinitely.
REQ-023 WRITE: assert oWriteSample for exactly one cycle (cycle after request); data and oSampleIndex stable from entry to REQUEST until leaving WRITE.
REQ-024 Leaving WRITE: if oSampleIndex==NUM_SAMPLES -> DONE, index held; else index+1, -> HUNT.
REQ-025 DONE: oLoadDone=1; all bytes ignored, no pulses, until reset.
REQ-026 iRxValid in REQUEST or WRITE: byte dropped, oOverrun pulses same cycle+1; state unaffected.
REQ-027 Latency: final payload byte at cycle T, iNextSample=1 -> oPreparingNextSample at T+1 (T+2 with checksum), oWriteSample one cycle later.
REQ-028 Data registers retain last assembled sample outside PAYLOAD; partially filled frames never written.
REQ-029 oPreparingNextSample and oWriteSample never asserted same cycle.

Reset
REQ-030 iReset=1: state HUNT, index 0, byte counter 0, all data outputs 0, all strobes/oLoadDone 0, effective next edge.
REQ-031 Reset mid-frame or in REQUEST/WRITE abandons sample; no write issued; iReset dominates all other inputs.

Configuration
REQ-032 Macro SAMPLE_CHECKSUM_EN defined: CHECK state expects 13th byte = XOR of 12 payload bytes; match -> REQUEST; mismatch -> oFrameError pulse, index unchanged, -> HUNT.
REQ-033 Macro undefined: CHECK state unreachable/absent, oFrameError tied 0, frame is header+12 bytes.

Verification
REQ-034 Reset, no bytes -> all outputs 0, oLoadDone 0 for 100 cycles.
REQ-035 Bytes 0x00,0x11 then A5 + 01..0C, iNextSample=1 -> one request, one write, Input=0x04030201, Expected=0x08070605, Valid=0x0C0B0A09, index 0.
REQ-036 Frame complete, iNextSample=0 for 20 cycles, byte sent meanwhile -> no strobes, oOverrun once; raise iNextSample -> request then write next cycle.
REQ-037 NUM_SAMPLES=3, four valid frames -> indices 0,1,2,3 written, oLoadDone=1 after fourth; fifth frame -> no strobes.
REQ-038 With SAMPLE_CHECKSUM_EN: A5+01..0C+0x0C -> written; A5+01..0C+0x00 -> oFrameError, index stays, next good frame written at same index.
REQ-039 iReset after byte 6 of payload, then full frame -> only that frame written, index 0.

Source files
------------

// File: rtl/serial_sample_loader_if.sv
// Byte-stream and sample-store signals of the serial sample loader.
// master drives the byte stream and store handshake, slave is the loader.
interface serial_sample_loader_if;
  logic            iRxValid;
  logic [7:0]      iRxData;
  logic            iNextSample;
  logic            oPreparingNextSample;
  logic            oWriteSample;
  logic [3:0][7:0] oCurrentSerialInput;
  logic [3:0][7:0] oCurrentSerialExpectedOutput;
  logic [3:0][7:0] oCurrentSerialValidOutput;
  logic [31:0]     oSampleIndex;
  logic            oLoadDone;
  logic            oFrameError;
  logic            oOverrun;

  modport slave (
    input  iRxValid,
    input  iRxData,
    input  iNextSample,
    output oPreparingNextSample,
    output oWriteSample,
    output oCurrentSerialInput,
    output oCurrentSerialExpectedOutput,
    output oCurrentSerialValidOutput,
    output oSampleIndex,
    output oLoadDone,
    output oFrameError,
    output oOverrun
  );

  modport master (
    output iRxValid,
    output iRxData,
    output iNextSample,
    input  oPreparingNextSample,
    input  oWriteSample,
    input  oCurrentSerialInput,
    input  oCurrentSerialExpectedOutput,
    input  oCurrentSerialValidOutput,
    input  oSampleIndex,
    input  oLoadDone,
    input  oFrameError,
    input  oOverrun
  );
endinterface

// File: rtl/serial_sample_loader.sv
// Assembles header-framed 12-byte samples and writes them to a sample store.
// Define SAMPLE_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module serial_sample_loader #(
  parameter int         NUM_SAMPLES = 15,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input logic                   iClock,
  input logic                   iReset,
  serial_sample_loader_if.slave bus
);

  typedef enum logic [2:0] {
    HUNT,
    PAYLOAD,
    CHECK,
    REQUEST,
    WRITE,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [3:0][7:0] r_in;
  logic [3:0][7:0] r_exp;
  logic [3:0][7:0] r_vld;
  logic [31:0]     r_idx;
  logic            r_ovr;
  logic            w_rx;
  logic            w_hdr;
  logic            w_last;
  logic            w_at_max;
  logic            w_busy;

  assign w_rx     = bus.iRxValid;
  assign w_hdr    = w_rx && (bus.iRxData == HEADER_BYTE);
  assign w_last   = (r_cnt == 4'd11);
  assign w_at_max = (r_idx == 32'(NUM_SAMPLES));
  assign w_busy   = (r_state == REQUEST) || (r_state == WRITE);

`ifdef SAMPLE_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_ferr;
  logic       w_sum_ok;

  assign w_sum_ok = (bus.iRxData == r_xor);
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HUNT: begin
        if (w_hdr) w_next = PAYLOAD;
      end
      PAYLOAD: begin
`ifdef SAMPLE_CHECKSUM_EN
        if (w_rx && w_last) w_next = CHECK;
`else
        if (w_rx && w_last) w_next = REQUEST;
`endif
      end
      CHECK: begin
`ifdef SAMPLE_CHECKSUM_EN
        if (w_rx) w_next = w_sum_ok ? REQUEST : HUNT;
`else
        w_next = HUNT;
`endif
      end
      REQUEST: begin
        if (bus.iNextSample) w_next = WRITE;
      end
      WRITE: begin
        w_next = w_at_max ? DONE : HUNT;
      end
      DONE: begin
        w_next = DONE;
      end
      default: begin
        w_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_cnt <= '0;
      r_in  <= '0;
      r_exp <= '0;
      r_vld <= '0;
      r_idx <= '0;
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= w_rx && w_busy;
      if (r_state == HUNT && w_hdr) begin
        r_cnt <= '0;
      end
      if (r_state == PAYLOAD && w_rx) begin
        r_cnt <= r_cnt + 4'd1;
        // byte counter bits [3:2] pick the word, [1:0] the lane
        unique case (r_cnt[3:2])
          2'd0:    r_in[r_cnt[1:0]]  <= bus.iRxData;
          2'd1:    r_exp[r_cnt[1:0]] <= bus.iRxData;
          default: r_vld[r_cnt[1:0]] <= bus.iRxData;
        endcase
      end
      if (r_state == WRITE && !w_at_max) begin
        r_idx <= r_idx + 32'd1;
      end
    end
  end

`ifdef SAMPLE_CHECKSUM_EN
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_xor  <= '0;
      r_ferr <= 1'b0;
    end else begin
      r_ferr <= (r_state == CHECK) && w_rx && !w_sum_ok;
      if (r_state == HUNT && w_hdr) begin
        r_xor <= '0;
      end else if (r_state == PAYLOAD && w_rx) begin
        r_xor <= r_xor ^ bus.iRxData;
      end
    end
  end

  assign bus.oFrameError = r_ferr;
`else
  assign bus.oFrameError = 1'b0;
`endif

  // strobes are masked by reset so an abandoned sample never reaches the store
  assign bus.oPreparingNextSample =
    (r_state == REQUEST) && bus.iNextSample && !iReset;
  assign bus.oWriteSample = (r_state == WRITE) && !iReset;
  assign bus.oLoadDone    = (r_state == DONE);
  assign bus.oOverrun     = r_ovr;
  assign bus.oSampleIndex = r_idx;

  assign bus.oCurrentSerialInput          = r_in;
  assign bus.oCurrentSerialExpectedOutput = r_exp;
  assign bus.oCurrentSerialValidOutput    = r_vld;

endmodule
